i2c_bus_arbiter: RTL
====================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL take parameter DATA_DEPTH, default 8, the width of every bits bus.
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 1024, the cycle limit for an active transaction.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 i_req_0/1  in  1  requester x wants the I2C master; level, held until o_done_x.
REQ-006 o_gnt_0/1  out  1  requester x owns the master.
REQ-007 i_start_0/1  in  1  requester start pulse, forwarded to o_start.
REQ-008 i_addr_bits_0/1, i_addr_valid_0/1 in, o_addr_ready_0/1 out  DATA_DEPTH/1/1  requester address channel.
REQ-009 i_nbytes_bits_0/1, i_nbytes_valid_0/1 in, o_nbytes_ready_0/1 out  DATA_DEPTH/1/1  requester read-length channel.
REQ-010 i_data_write_bits_0/1, i_data_write_valid_0/1 in, o_data_write_ready_0/1 out  DATA_DEPTH/1/1  requester write channel.
REQ-011 o_data_read_bits_0/1, o_data_read_valid_0/1 out, i_data_read_ready_0/1 in  DATA_DEPTH/1/1  requester read channel.
REQ-012 o_done_0/1, o_nak_0/1  out  1/1  end-of-transaction pulse, with NAK status valid on the same cycle.
REQ-013 o_start; o_addr_bits, o_addr_valid, i_addr_ready; o_nbytes_bits, o_nbytes_valid, i_nbytes_ready; o_data_write_bits, o_data_write_valid, i_data_write_ready; i_data_read_bits, i_data_read_valid, o_data_read_ready; i_nak  master-side port; i_addr_ready high means the master is idle.
REQ-014 o_timeout  out  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-015 SHALL implement states IDLE, GRANT, ACTIVE and DONE.
REQ-016 IDLE: both o_gnt low, all master-side outputs 0, all requester readies/valids 0.
REQ-017 IDLE: if any i_req_x and i_addr_ready, then next cycle GRANT with o_gnt_x=1, o_gnt_x registered.
REQ-018 Round-robin: on simultaneous requests, grant the requester not granted last; pointer updates only in DONE.
REQ-019 GRANT/ACTIVE: master-side outputs SHALL combinationally equal the granted requester's inputs (zero added latency).
REQ-020 GRANT/ACTIVE: granted requester's readies/read-valid/read-bits SHALL mirror the master; the non-granted requester sees all 0.
REQ-021 GRANT to ACTIVE when i_addr_ready is sampled low (master accepted the address).
REQ-022 GRANT: if i_req_x drops before the address is accepted, return to IDLE; no o_done, pointer unchanged.
REQ-023 ACTIVE: i_req_x changes are ignored.
REQ-024 ACTIVE to DONE when i_addr_ready is sampled high again.
REQ-025 DONE (one cycle): o_gnt low, o_done_x=1, o_nak_x = i_nak sampled at the ACTIVE to DONE edge, pointer = x; then IDLE.
REQ-026 DONE: master-side outputs 0; a new grant is possible no earlier than the cycle after DONE.
REQ-027 ACTIVE counter SHALL clear on GRANT to ACTIVE, increment each ACTIVE cycle, and saturate.
REQ-028 If the counter reaches TIMEOUT_CYCLES-1 before i_addr_ready rises, go to DONE with o_nak_x=1 and o_timeout=1 for that cycle.
REQ-029 o_done, o_nak and o_timeout SHALL be registered outputs.
REQ-030 Requests arriving while the master is not idle (i_addr_ready low) in IDLE SHALL wait; no grant is issued.

Reset
REQ-031 i_rst low SHALL force IDLE immediately, including mid-transaction.
REQ-032 Reset values: o_gnt, o_done, o_nak and o_timeout at 0, all master-side outputs at 0, counter at 0.
REQ-033 Round-robin pointer resets to 1 so requester 0 wins the first tie.
REQ-034 Outputs are combinational muxes gated by state, so they are 0 from reset assertion with no clock.

Verification
REQ-035 Reset release, i_req_0=i_req_1=1 same cycle, i_addr_ready=1 -> o_gnt_0=1 next cycle; after done, o_gnt_1=1 one cycle after DONE.
REQ-036 Req 0 granted, addr 0x4E valid, master drops i_addr_ready, raises it 20 cycles later with i_nak=0 -> o_done_0=1, o_nak_0=0 for exactly 1 cycle.
REQ-037 Same as REQ-036 with i_nak=1 at completion -> o_nak_0=1; requester 1 write-ready stays 0 throughout.
REQ-038 TIMEOUT_CYCLES=16, master holds i_addr_ready low -> o_timeout=o_done_x=o_nak_x=1 on the 16th ACTIVE cycle; master valids 0 next cycle.
REQ-039 i_req_1 dropped in GRANT before addr accept -> IDLE, no o_done_1; pending i_req_0 granted next.
REQ-040 i_rst low mid-ACTIVE -> o_gnt and all master valids 0 asynchronously; after release, IDLE with pointer=1.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Two-requester arbiter in front of a single I2C master.
// Round-robin grant, transparent channel muxing, and an ACTIVE-phase timeout.
module i2c_bus_arbiter #(
    parameter int DATA_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_0,
    input  logic                  i_req_1,
    output logic                  o_gnt_0,
    output logic                  o_gnt_1,
    input  logic                  i_start_0,
    input  logic                  i_start_1,
    input  logic [DATA_DEPTH-1:0] i_addr_bits_0,
    input  logic [DATA_DEPTH-1:0] i_addr_bits_1,
    input  logic                  i_addr_valid_0,
    input  logic                  i_addr_valid_1,
    output logic                  o_addr_ready_0,
    output logic                  o_addr_ready_1,
    input  logic [DATA_DEPTH-1:0] i_nbytes_bits_0,
    input  logic [DATA_DEPTH-1:0] i_nbytes_bits_1,
    input  logic                  i_nbytes_valid_0,
    input  logic                  i_nbytes_valid_1,
    output logic                  o_nbytes_ready_0,
    output logic                  o_nbytes_ready_1,
    input  logic [DATA_DEPTH-1:0] i_data_write_bits_0,
    input  logic [DATA_DEPTH-1:0] i_data_write_bits_1,
    input  logic                  i_data_write_valid_0,
    input  logic                  i_data_write_valid_1,
    output logic                  o_data_write_ready_0,
    output logic                  o_data_write_ready_1,
    output logic [DATA_DEPTH-1:0] o_data_read_bits_0,
    output logic [DATA_DEPTH-1:0] o_data_read_bits_1,
    output logic                  o_data_read_valid_0,
    output logic                  o_data_read_valid_1,
    input  logic                  i_data_read_ready_0,
    input  logic                  i_data_read_ready_1,
    output logic                  o_done_0,
    output logic                  o_done_1,
    output logic                  o_nak_0,
    output logic                  o_nak_1,
    output logic                  o_start,
    output logic [DATA_DEPTH-1:0] o_addr_bits,
    output logic                  o_addr_valid,
    input  logic                  i_addr_ready,
    output logic [DATA_DEPTH-1:0] o_nbytes_bits,
    output logic                  o_nbytes_valid,
    input  logic                  i_nbytes_ready,
    output logic [DATA_DEPTH-1:0] o_data_write_bits,
    output logic                  o_data_write_valid,
    input  logic                  i_data_write_ready,
    input  logic [DATA_DEPTH-1:0] i_data_read_bits,
    input  logic                  i_data_read_valid,
    output logic                  o_data_read_ready,
    input  logic                  i_nak,
    output logic                  o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, DONE} state_t;

    state_t        state;
    logic          owner;
    logic          rr_ptr;
    logic [CW-1:0] cnt;
    logic          live;
    logic          sel0;
    logic          sel1;
    logic          pick;
    logic          own_req;
    logic          other_req;

    assign live      = (state == GRANT) || (state == ACTIVE);
    assign sel0      = live && !owner;
    assign sel1      = live && owner;
    assign own_req   = owner ? i_req_1 : i_req_0;
    assign other_req = owner ? i_req_0 : i_req_1;
    // rr_ptr holds the last owner, so a tie goes to the other side
    assign pick      = (i_req_0 && i_req_1) ? !rr_ptr : i_req_1;

    assign o_gnt_0 = sel0;
    assign o_gnt_1 = sel1;

    assign o_start            = (sel0 && i_start_0) || (sel1 && i_start_1);
    assign o_addr_bits        = ({DATA_DEPTH{sel0}} & i_addr_bits_0)
                              | ({DATA_DEPTH{sel1}} & i_addr_bits_1);
    assign o_addr_valid       = (sel0 && i_addr_valid_0) || (sel1 && i_addr_valid_1);
    assign o_nbytes_bits      = ({DATA_DEPTH{sel0}} & i_nbytes_bits_0)
                              | ({DATA_DEPTH{sel1}} & i_nbytes_bits_1);
    assign o_nbytes_valid     = (sel0 && i_nbytes_valid_0) || (sel1 && i_nbytes_valid_1);
    assign o_data_write_bits  = ({DATA_DEPTH{sel0}} & i_data_write_bits_0)
                              | ({DATA_DEPTH{sel1}} & i_data_write_bits_1);
    assign o_data_write_valid = (sel0 && i_data_write_valid_0)
                              || (sel1 && i_data_write_valid_1);
    assign o_data_read_ready  = (sel0 && i_data_read_ready_0)
                              || (sel1 && i_data_read_ready_1);

    assign o_addr_ready_0       = sel0 && i_addr_ready;
    assign o_addr_ready_1       = sel1 && i_addr_ready;
    assign o_nbytes_ready_0     = sel0 && i_nbytes_ready;
    assign o_nbytes_ready_1     = sel1 && i_nbytes_ready;
    assign o_data_write_ready_0 = sel0 && i_data_write_ready;
    assign o_data_write_ready_1 = sel1 && i_data_write_ready;
    assign o_data_read_bits_0   = {DATA_DEPTH{sel0}} & i_data_read_bits;
    assign o_data_read_bits_1   = {DATA_DEPTH{sel1}} & i_data_read_bits;
    assign o_data_read_valid_0  = sel0 && i_data_read_valid;
    assign o_data_read_valid_1  = sel1 && i_data_read_valid;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b1;
            cnt       <= '0;
            o_done_0  <= 1'b0;
            o_done_1  <= 1'b0;
            o_nak_0   <= 1'b0;
            o_nak_1   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_done_0  <= 1'b0;
            o_done_1  <= 1'b0;
            o_nak_0   <= 1'b0;
            o_nak_1   <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if ((i_req_0 || i_req_1) && i_addr_ready) begin
                        state <= GRANT;
                        owner <= pick;
                    end
                end
                GRANT: begin
                    if (!i_addr_ready) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                    end else if (!own_req) begin
                        state <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    // a master completion wins over a coincident timeout
                    if (i_addr_ready || cnt >= CNT_PRE) begin
                        state     <= DONE;
                        rr_ptr    <= owner;
                        o_done_0  <= !owner;
                        o_done_1  <= owner;
                        o_nak_0   <= !owner && (!i_addr_ready || i_nak);
                        o_nak_1   <= owner && (!i_addr_ready || i_nak);
                        o_timeout <= !i_addr_ready;
                    end
                end
                DONE: begin
                    // the finishing owner may still hold its request this cycle
                    if (other_req && i_addr_ready) begin
                        state <= GRANT;
                        owner <= !owner;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
